// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux sequencer.
// MSB_FIRST_EN selects MSB-first select order (default is LSB-first).
package mux_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef MSB_FIRST_EN
    localparam logic [SEL_W-1:0] START_SEL = 3'd7;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd0;
`else
    localparam logic [SEL_W-1:0] START_SEL = 3'd0;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd7;
`endif

    // Moves the select one position toward LAST_SEL.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
`ifdef MSB_FIRST_EN
        return sel - SEL_W'(1);
`else
        return sel + SEL_W'(1);
`endif
    endfunction

endpackage

// File: rtl/mux_8to1_seq_div.sv
// Bit-slot pacing counter: counts 0..DIV-1 and flags the last clock of a slot.
// The count reloads explicitly on clr or at the end of a slot, never by overflow.
module bit_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_8to1_seq.sv
// Paced parallel-to-serial sequencer driving an 8-to-1 mux, with a feedback
// checker on the mux output. Select order follows MSB_FIRST_EN (see package).
module mux_8to1_seq
    import mux_seq_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [DATA_W-1:0] i,
    output logic [SEL_W-1:0]  s,
    input  logic              y,
    output logic              ser_valid,
    output logic              frame_done,
    input  logic              err_clr,
    output logic              err
);

    state_t state;
    state_t state_nxt;
    logic   tick;
    logic   div_clr;
    logic   accept;
    logic   sample;
    logic   mismatch;

    // The slot counter only runs in SHIFT, so every frame starts at count 0.
    assign div_clr  = (state != SHIFT);
    assign accept   = (state == IDLE) && load_valid;
    assign sample   = (state == SHIFT) && tick;
    assign mismatch = sample && (y != i[s]);

    bit_tick_div #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (sample && (s == LAST_SEL)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE);
        ser_valid  = (state == SHIFT);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            s <= START_SEL;
        end else begin
            if (accept) begin
                i <= data_in;
            end
            if (accept || (state == DONE)) begin
                s <= START_SEL;
            end else if (sample && (s != LAST_SEL)) begin
                s <= next_sel(s);
            end
        end
    end

    // A new mismatch wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_8to1_seq.sv
// Bench for mux_8to1_seq: DIV=4 instance plus a DIV=1 instance, each wired to
// a behavioural 8-to-1 mux. Expected select order follows MSB_FIRST_EN.
module tb_mux_8to1_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] i;
    logic [2:0] s;
    logic       y;
    logic       ser_valid;
    logic       frame_done;
    logic       err_clr;
    logic       err;
    logic       force_y0;

    logic [7:0] b_data_in;
    logic       b_load_valid;
    logic       b_load_ready;
    logic [7:0] b_i;
    logic [2:0] b_s;
    logic       b_y;
    logic       b_ser_valid;
    logic       b_frame_done;
    logic       b_err_clr;
    logic       b_err;

    // 8-to-1 muxes; the first can have its output stuck low while s == 2.
    always_comb y   = (force_y0 && (s == 3'd2)) ? 1'b0 : i[s];
    always_comb b_y = b_i[b_s];

    mux_8to1_seq #(.DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .i          (i),
        .s          (s),
        .y          (y),
        .ser_valid  (ser_valid),
        .frame_done (frame_done),
        .err_clr    (err_clr),
        .err        (err)
    );

    mux_8to1_seq #(.DIV(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (b_data_in),
        .load_valid (b_load_valid),
        .load_ready (b_load_ready),
        .i          (b_i),
        .s          (b_s),
        .y          (b_y),
        .ser_valid  (b_ser_valid),
        .frame_done (b_frame_done),
        .err_clr    (b_err_clr),
        .err        (b_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Select value expected for the k-th emitted bit.
    function automatic logic [2:0] exp_sel(input int k);
`ifdef MSB_FIRST_EN
        return 3'(7 - k);
`else
        return 3'(k);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word on the DIV=4 instance and check the whole frame.
    // ypat[k] is the hand-derived y value of the k-th emitted bit.
    task automatic run_frame(input logic [7:0] w, input logic [7:0] ypat, input string tag);
        check({tag, " ready before"}, load_ready, 1);
        load_valid = 1'b1;
        data_in    = w;
        step();
        load_valid = 1'b0;
        data_in    = 8'h00;
        for (int c = 0; c < 32; c++) begin
            check({tag, " s"}, s, exp_sel(c / 4));
            check({tag, " y"}, y, ypat[c / 4]);
            check({tag, " ser_valid"}, ser_valid, 1);
            check({tag, " frame_done early"}, frame_done, 0);
            step();
        end
        check({tag, " frame_done"}, frame_done, 1);
        check({tag, " ser_valid after"}, ser_valid, 0);
        check({tag, " ready in done"}, load_ready, 0);
        step();
        check({tag, " ready again"}, load_ready, 1);
        check({tag, " frame_done drop"}, frame_done, 0);
        check({tag, " s home"}, s, exp_sel(0));
        check({tag, " i held"}, i, w);
    endtask

    task automatic wait_s2(input string tag);
        int n;
        n = 0;
        while (!(ser_valid && s == 3'd2) && n < 60) begin
            step();
            n++;
        end
        check({tag, " reach s2"}, s, 2);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!load_ready && n < 60) begin
            step();
            n++;
        end
        check({tag, " idle"}, load_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int overlap;

        rst_n        = 1'b0;
        data_in      = 8'h00;
        load_valid   = 1'b0;
        err_clr      = 1'b0;
        force_y0     = 1'b0;
        b_data_in    = 8'h00;
        b_load_valid = 1'b0;
        b_err_clr    = 1'b0;

        // Reset and idle
        step();
        step();
        check("rst load_ready", load_ready, 1);
        check("rst s", s, exp_sel(0));
        check("rst i", i, 0);
        rst_n = 1'b1;
        step();
        check("idle load_ready", load_ready, 1);
        check("idle s", s, exp_sel(0));
        check("idle i", i, 0);
        check("idle err", err, 0);
        check("idle ser_valid", ser_valid, 0);
        check("idle frame_done", frame_done, 0);

        // Single frame, A5 emits 1,0,1,0,0,1,0,1 in either order
        run_frame(8'hA5, 8'b1010_0101, "a5");
        check("a5 err", err, 0);

        // Back-to-back frames with load_valid held
        load_valid = 1'b1;
        data_in    = 8'h3C;
        step();
        check("b2b first i", i, 8'h3C);
        check("b2b first ser_valid", ser_valid, 1);
        data_in = 8'hFF;
        n       = 1;
        pulses  = 0;
        overlap = 0;
        while (i != 8'hFF && n < 100) begin
            if (frame_done) pulses++;
            if (frame_done && ser_valid) overlap++;
            step();
            n++;
        end
        check("b2b spacing", n - 1, 34);
        load_valid = 1'b0;
        data_in    = 8'h00;
        while (!load_ready && n < 200) begin
            if (frame_done) pulses++;
            if (frame_done && ser_valid) overlap++;
            step();
            n++;
        end
        check("b2b end idle", load_ready, 1);
        check("b2b done pulses", pulses, 2);
        check("b2b overlap", overlap, 0);
        check("b2b err", err, 0);

        // Fault injection: y stuck low while s == 2, word bit 2 is 1
        force_y0   = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'h04;
        step();
        load_valid = 1'b0;
        wait_s2("flt1");
        check("flt1 y forced", y, 0);
        check("flt1 err before", err, 0);
        for (int c = 0; c < 4; c++) step();
        check("flt1 err set", err, 1);
        wait_idle("flt1");
        check("flt1 err sticky", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("flt1 err cleared", err, 0);

        // err_clr held across a mismatch sample point: set wins
        load_valid = 1'b1;
        data_in    = 8'h04;
        step();
        load_valid = 1'b0;
        wait_s2("flt2");
        err_clr = 1'b1;
        for (int c = 0; c < 4; c++) step();
        err_clr = 1'b0;
        check("flt2 set beats clr", err, 1);
        wait_idle("flt2");
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        force_y0 = 1'b0;
        check("flt2 err cleared", err, 0);

        // Mid-frame reset during bit 3 of 81
        load_valid = 1'b1;
        data_in    = 8'h81;
        step();
        load_valid = 1'b0;
        n = 0;
        while (s != exp_sel(3) && n < 60) begin
            step();
            n++;
        end
        check("mrst reach bit3", s, exp_sel(3));
        step();
        rst_n = 1'b0;
        #1;
        check("mrst load_ready", load_ready, 1);
        check("mrst s", s, exp_sel(0));
        check("mrst i", i, 0);
        check("mrst ser_valid", ser_valid, 0);
        check("mrst frame_done", frame_done, 0);
        check("mrst err", err, 0);
        step();
        check("mrst no done 1", frame_done, 0);
        step();
        check("mrst no done 2", frame_done, 0);
        rst_n = 1'b1;
        step();
        check("mrst no done 3", frame_done, 0);
        run_frame(8'h81, 8'b1000_0001, "after_rst");

        // DIV=1 instance with word 01
        b_load_valid = 1'b1;
        b_data_in    = 8'h01;
        step();
        b_load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("div1 s", b_s, exp_sel(k));
            check("div1 y", b_y, (exp_sel(k) == 3'd0) ? 1 : 0);
            check("div1 ser_valid", b_ser_valid, 1);
            step();
        end
        check("div1 frame_done", b_frame_done, 1);
        check("div1 ser_valid after", b_ser_valid, 0);
        step();
        check("div1 ready", b_load_ready, 1);
        check("div1 err", b_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_8to1_seq.md
# mux_8to1_seq

Sequencer that sits directly upstream of the 8-to-1 mux and turns it into a paced parallel-to-serial stage. It accepts one 8-bit word through a valid/ready handshake, holds the word on the mux data inputs and steps the mux select through all eight positions, one bit every DIV clocks. It also takes the mux output back in and checks it against the expected bit, raising a sticky error flag on any mismatch.

## Interface
- DIV, default 4: clocks per bit slot; legal range 1..256.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  word to serialise.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word; equals (state == IDLE).
- i  output  8  registered word driven to the mux data inputs.
- s  output  3  registered select driven to the mux.
- y  input  1  mux output, fed back for checking.
- ser_valid  output  1  high while i/s present a live bit (SHIFT state).
- frame_done  output  1  one-cycle pulse after the 8th bit completes.
- err_clr  input  1  synchronous clear of err.
- err  output  1  sticky flag; y disagreed with i[s] at a sample point.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready = 1.
  - When load_valid && load_ready at a clock edge: i <= data_in; s <= START; div_cnt <= 0; go to SHIFT.
- SHIFT:
  - ser_valid = 1; div_cnt counts 0..DIV-1.
  - When div_cnt == DIV-1, this is the sample point: compare y with i[s] and set err on mismatch.
  - At the sample point, if s == LAST, go to DONE; otherwise step s toward LAST and reset div_cnt to 0.
- DONE:
  - frame_done = 1 for exactly this one cycle.
  - s <= START; go to IDLE.
- START/LAST: 0/7 by default (LSB first); 7/0 with MSB_FIRST_EN.
- i holds its last word until the next accept. In IDLE, s sits at START.
- load_valid is ignored outside IDLE. No word is dropped: the upstream source must hold load_valid until it is accepted.
- err behaviour:
  - Set takes priority over err_clr in the same cycle.
  - err_clr with no mismatch clears err on the next edge.
  - err is never cleared by frame boundaries.
- Reset values:
  - state = IDLE; i = 0; s = START; div_cnt = 0.
  - ser_valid = 0; frame_done = 0; err = 0; load_ready = 1.
- Reset mid-frame aborts the frame immediately with no frame_done pulse. After reset release, the block returns to IDLE and is ready.

## Timing
- Accept edge T0: i and s are valid from T0+1, and ser_valid rises at T0+1.
- Each bit is held for exactly DIV cycles. Bit k (k = 0..7) occupies cycles T0+1+k*DIV through T0+(k+1)*DIV.
- frame_done is high in cycle T0+8*DIV+1. load_ready is high again from T0+8*DIV+2.
- Minimum accept-to-accept spacing is 8*DIV+2 cycles.
- y is sampled combinationally in the same cycle as the sample point; the mux has zero latency.
- With DIV = 1 the sample point is every SHIFT cycle and the frame lasts 8 cycles.
- div_cnt width is clog2(DIV), minimum 1 bit. All counters wrap only through explicit reload, never by overflow.

## Configuration
- MSB_FIRST_EN defined: s counts 7 down to 0, so bit 7 is emitted first.
- MSB_FIRST_EN undefined: s counts 0 up to 7 (LSB first).
- Handshake, timing and the error check are identical in both builds; only START, LAST and the step direction change.

## Structure
- Package mux_seq_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - localparams DATA_W = 8 and SEL_W = 3;
  - START_SEL/LAST_SEL, derived under MSB_FIRST_EN.
- One sub-module, bit_tick_div (parameter DIV):
  - inputs: clk, rst_n, clr;
  - output: tick, high when the count equals DIV-1.
- The top level holds the FSM, the i/s registers and the checker.
- The testbench instantiates mux_8to1_seq alongside the 8-to-1 mux, with s/i/y wired between them.

## Test plan
- Reset then idle (DIV=4, LSB first): after rst_n release → load_ready=1, s=0, i=0, err=0, ser_valid=0.
- Single frame: accept data_in=8'hA5 at T0 → s steps 0,1,…,7, each held 4 cycles; y traces 1,0,1,0,0,1,0,1; frame_done high at T0+33; err stays 0.
- Back-to-back frames: hold load_valid high with 8'h3C then 8'hFF → the second word is accepted exactly 34 cycles after the first; no overlap of ser_valid; two frame_done pulses.
- Fault injection: force y to 0 while s=2 with word 8'h04 → err=1 after that sample point and stays set; asserting err_clr alone in a later cycle → err=0 on the next edge; err_clr asserted in the same cycle as a mismatch → err stays 1.
- Mid-frame reset: assert rst_n=0 during bit 3 of 8'h81 → all outputs take their reset values immediately, no frame_done pulse, and the next accepted word serialises correctly.
- MSB_FIRST_EN build, DIV=1: word 8'h01 → s steps 7 down to 0 on consecutive cycles; y=1 only in the 8th SHIFT cycle; frame_done in the following cycle.
